// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: states, opcodes,
// datapath mux selects and the bundled control word.
package multicycle_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_IF      = 4'd0,
        S_ID      = 4'd1,
        S_EX_R    = 4'd2,
        S_EX_I    = 4'd3,
        S_EX_ADDR = 4'd4,
        S_MEM_LD  = 4'd5,
        S_WB_LD   = 4'd6,
        S_MEM_ST  = 4'd7,
        S_EX_BR   = 4'd8,
        S_PC_INC  = 4'd9,
        S_EX_JAL  = 4'd10,
        S_EX_JALR = 4'd11,
        S_WB_JALR = 4'd12,
        S_ECALL   = 4'd13,
        S_HALT    = 4'd14,
        S_WB_ALU  = 4'd15
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] SRCB_B    = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC4    = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mdr_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_source;
        logic       is_ecall;
    } ctrl_t;

    // Overlay the sequential-PC update (PC <= PC + 4) onto a control word.
    function automatic ctrl_t with_pc_plus4(input ctrl_t c);
        ctrl_t r;
        r           = c;
        r.alu_src_a = 1'b0;
        r.alu_src_b = SRCB_FOUR;
        r.alu_op    = ALU_ADD;
        r.pc_source = 1'b0;
        r.pc_write  = 1'b1;
        return r;
    endfunction

    function automatic state_e ex_state_for(input logic [6:0] op);
        case (op)
            OP_R:               return S_EX_R;
            OP_I:               return S_EX_I;
            OP_LOAD, OP_STORE:  return S_EX_ADDR;
            OP_BRANCH:          return S_EX_BR;
            OP_JAL:             return S_EX_JAL;
            OP_JALR:            return S_EX_JALR;
            OP_SYSTEM:          return S_ECALL;
            default:            return S_PC_INC;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_output_decode.sv
// Combinational control-word decode from the current state plus the
// memory, branch and halt handshakes.
module control_output_decode
    import multicycle_control_fsm_pkg::*;
(
    input  state_e     state,
    input  logic       reset,
    input  logic       mem_ready,
    input  logic       bcond,
    input  logic       is_halted,
    output ctrl_t      ctrl
);

    // NOTE: ctrl gets a full default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        ctrl = '0;
        case (state)
            S_IF: begin
                ctrl.mem_read = 1'b1;
                ctrl.ir_write = mem_ready;
            end
            S_ID: begin
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_EX_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_EX_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_WB_ALU: begin
                ctrl            = with_pc_plus4(ctrl);
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = M2R_ALUOUT;
            end
            S_EX_ADDR, S_EX_JALR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEM_LD: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b1;
                ctrl.mdr_write = mem_ready;
            end
            S_WB_LD: begin
                ctrl            = with_pc_plus4(ctrl);
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = M2R_MDR;
            end
            S_MEM_ST: begin
                if (mem_ready) ctrl = with_pc_plus4(ctrl);
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EX_BR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_write  = bcond;
                ctrl.pc_source = bcond;
            end
            S_PC_INC: begin
                ctrl = with_pc_plus4(ctrl);
            end
            // Link value PC+4 comes from the ALU while the jump target sits in ALUOut.
            S_EX_JAL, S_WB_JALR: begin
                ctrl            = with_pc_plus4(ctrl);
                ctrl.pc_source  = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = M2R_PC4;
            end
            S_ECALL: begin
                if (!is_halted) ctrl = with_pc_plus4(ctrl);
                ctrl.is_ecall = 1'b1;
            end
            default: ctrl = '0;
        endcase

        if (reset) begin
            ctrl.pc_write  = 1'b0;
            ctrl.ir_write  = 1'b0;
            ctrl.mdr_write = 1'b0;
            ctrl.reg_write = 1'b0;
            ctrl.mem_read  = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.is_ecall  = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control FSM: state sequencing, sticky halt flag and
// retired-instruction counter; output decode lives in control_output_decode.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             bcond,
    input  logic             mem_ready,
    input  logic             is_halted,
    output logic             pc_write,
    output logic             ir_write,
    output logic             mdr_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             pc_source,
    output logic             is_ecall,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             halted_q, halted_d;
    logic             retire;
    ctrl_t            ctrl;

    control_output_decode u_decode (
        .state     (state_q),
        .reset     (reset),
        .mem_ready (mem_ready),
        .bcond     (bcond),
        .is_halted (is_halted),
        .ctrl      (ctrl)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:      if (mem_ready) state_d = S_ID;
            S_ID:      state_d = ex_state_for(opcode);
            S_EX_R,
            S_EX_I:    state_d = S_WB_ALU;
            S_EX_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_LD : S_MEM_ST;
            S_MEM_LD:  if (mem_ready) state_d = S_WB_LD;
            S_MEM_ST:  if (mem_ready) state_d = S_IF;
            S_EX_BR:   state_d = bcond ? S_IF : S_PC_INC;
            S_EX_JALR: state_d = S_WB_JALR;
            S_ECALL:   state_d = is_halted ? S_HALT : S_IF;
            S_HALT:    state_d = S_HALT;
            S_WB_ALU, S_WB_LD, S_PC_INC,
            S_EX_JAL, S_WB_JALR: state_d = S_IF;
            default:   state_d = S_IF;
        endcase

        // NOTE: reset is synchronous, so it is folded into the next-state values rather than the flop sensitivity.
        if (reset) state_d = S_IF;

        // An instruction retires when control returns to IF or parks in HALT.
        retire   = !reset && (((state_d == S_IF)   && (state_q != S_IF)) ||
                              ((state_d == S_HALT) && (state_q != S_HALT)));
        count_d  = reset ? '0 : (retire ? count_q + CNT_W'(1) : count_q);
        halted_d = !reset && (halted_q || (state_d == S_HALT));
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        state_q  <= state_d;
        count_q  <= count_d;
        halted_q <= halted_d;
    end

    assign pc_write    = ctrl.pc_write;
    assign ir_write    = ctrl.ir_write;
    assign mdr_write   = ctrl.mdr_write;
    assign i_or_d      = ctrl.i_or_d;
    assign mem_read    = ctrl.mem_read;
    assign mem_write   = ctrl.mem_write;
    assign reg_write   = ctrl.reg_write;
    assign mem_to_reg  = ctrl.mem_to_reg;
    assign alu_src_a   = ctrl.alu_src_a;
    assign alu_src_b   = ctrl.alu_src_b;
    assign alu_op      = ctrl.alu_op;
    assign pc_source   = ctrl.pc_source;
    assign is_ecall    = ctrl.is_ecall;
    assign halted      = halted_q;
    assign instr_count = count_q;
    assign state       = state_q;

endmodule
